// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with a word FIFO.
// Configurable data width, parity and stop bits; baud by clock enable.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);
    localparam logic            ODD       = (PARITY == 1);
    localparam logic            HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [CW-1:0]       baud_q, baud_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic                txd_q, txd_d;
    logic                full, empty, push, pop, tick;

    // FIFO bookkeeping, frame sequencing and next line level
    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        push     = valid && !full;
        tick     = (baud_q == BAUD_LAST);
        pop      = 1'b0;
        state_d  = state_q;
        baud_d   = tick ? '0 : baud_q + CW'(1);
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        par_d    = par_q;

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop loads the head word and restarts bit timing
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            par_d   = ^mem_q[rd_ptr_q];
            baud_d  = '0;
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end

        unique case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_d ^ ODD;
            default:  txd_d = 1'b1;
        endcase
    end

    // Word storage; contents are only meaningful below count_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // State registers; reset abandons any frame and idles the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
        end
    end

    assign ready      = !full;
    assign TxD        = txd_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the loopback/serial datapath, replacing the fixed 8N2, start-pulse transmitter. It accepts words over a valid/ready handshake into an internal FIFO. It serialises each word LSB-first with configurable data width, parity and stop bits. Bit timing comes from an internal clock-enable divider; there is no derived clock, and everything runs on `clk`.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per serial bit (50 MHz / 115200); legal ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; legal 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `FIFO_DEPTH`, default 4: word buffer depth; power of two, ≥ 2.

Ports:
- `clk` input 1: sole clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `data` input DATA_BITS: word to send; sampled when `valid && ready`.
- `valid` input 1: `data` is valid this cycle.
- `ready` output 1: FIFO can accept a word.
- `TxD` output 1: serial line; idle high.
- `busy` output 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count` output clog2(FIFO_DEPTH)+1: words held in the FIFO, excluding the word being shifted.

## Operation
- Reset, asynchronous, while `rst_n` = 0:
  - `TxD` = 1, `ready` = 1, `busy` = 0, `fifo_count` = 0.
  - FSM goes to IDLE, the FIFO is emptied, and the baud counter is cleared.
  - An in-flight frame is abandoned; the line returns high immediately.
- FIFO:
  - Push on `valid && ready`.
  - `ready` = !full and depends on fullness only. When full, a push is refused even in a cycle where a pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - `valid` while full is ignored and the word is not stored. The source must hold it.
- FSM states:
  - IDLE → START: when FIFO non-empty. The head word is popped into the shift register.
  - START → DATA: after one bit time.
  - DATA: runs DATA_BITS bit times, LSB first.
  - DATA → PARITY if PARITY ≠ 0, else DATA → STOP.
  - PARITY → STOP: after one bit time.
  - STOP: runs STOP_BITS bit times. Then START if the FIFO is non-empty (pop in the same cycle, no idle gap), else IDLE.
- Line levels:
  - START drives 0; DATA drives the current shift bit; STOP and IDLE drive 1.
  - PARITY drives XOR of the data bits (even) or its inverse (odd).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on entry to START.
  - The terminal count advances the bit index or state.
  - Width is clog2(CLKS_PER_BIT).
- `busy` = (state ≠ IDLE) || (fifo_count ≠ 0).

## Timing
- `TxD` is a registered output; there is no combinational path from inputs to `TxD`.
- Latency, word accepted at edge N with FIFO empty and FSM IDLE:
  - `fifo_count` = 1 after edge N.
  - Pop at edge N+1: `TxD` = 0 and `fifo_count` = 0 after edge N+1.
- Every bit holds for exactly CLKS_PER_BIT cycles.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- `ready` falls the cycle after the push that fills the FIFO. It rises the cycle after the pop that frees a slot.
- Simultaneous push and pop with the FIFO not full: `fifo_count` is unchanged.
- `busy` falls the cycle after the final stop bit ends with the FIFO empty.

## Test plan
- 8N1 with CLKS_PER_BIT=4: push 0xA5.
  - Expect `TxD` bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, low first seen after edge N+1.
  - `busy` high for 40 cycles after the pop.
- 8E1 with 0xA5: parity bit 0 (frame 11 bits). 8O1 with 0xA5: parity bit 1. 7N2 with 0x55: bits 0,1,0,1,0,1,0,1,1,1.
- FIFO_DEPTH=4: hold `valid` high with 0x01..0x06.
  - `ready` drops once the FIFO holds 4 words behind the active word.
  - All 6 frames go out in order with zero idle cycles between stop and start.
- `valid` pulsed while full: the word is dropped and `fifo_count` stays 4. Later words still arrive in order.
- Reset mid-frame: assert `rst_n`=0 during data bit 3.
  - `TxD` goes high asynchronously, `fifo_count`=0, `busy`=0.
  - After release, push 0x3C: a clean full frame is sent.
- Push of one word in the same cycle as a pop from a 2-deep FIFO: `fifo_count` unchanged and `ready` stays high.
